// File: rtl/excdec_pkg.sv
// excdec_pkg
// Shared definitions for the exception-aware opcode decode pipeline:
// opcode constants, exception cause codes, the pipeline state enum and
// the packed control word carried from the decoder to the output register.
package excdec_pkg;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_ERET = 11'b11010110100;

   // CBZ and B are matched on a prefix only; the remaining low bits
   // belong to the immediate field and do not affect decode.
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
   localparam logic [5:0]  OP_B_PFX   = 6'b000101;

   localparam int EXC_NONE  = 0;
   localparam int EXC_INVOP = 2;

   typedef enum logic {
      RUN,
      EXC_WAIT
   } state_t;

   typedef struct packed {
      logic       reg2loc;
      logic [1:0] alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic       uncondbranch;
      logic [1:0] aluop;
      logic       eret;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/excdec_pipe_opdec.sv
// opdec_comb
// Purely combinational opcode decoder. Maps the 11-bit opcode field to a
// control word and flags anything it does not recognise as invalid (the
// control word is then all zero).
// Ports:
//   Op      in  OP_W  opcode field, only bits [10:0] are decoded
//   ctrl    out       decoded control word
//   invalid out 1     opcode not recognised
// Configuration:
//   EXCDEC_UNCOND_BRANCH_EN  when defined, B (Op[10:5]=000101) decodes as an
//                            unconditional branch; otherwise B is invalid.
module opdec_comb
   import excdec_pkg::*;
#(
   parameter int OP_W = 11
) (
   input  logic [OP_W-1:0] Op,
   output ctrl_t           ctrl,
   output logic            invalid
);

   logic [10:0] op11;

   assign op11 = Op[10:0];

   // Upper opcode bits take no part in decode.
   generate
      if (OP_W > 11) begin : g_wide
         logic unused_high;
         assign unused_high = ^Op[OP_W-1:11];
      end
   endgenerate

   // Exact-match opcodes first; prefix-matched branches fall through to the
   // default arm. A plain case never matches unknown bits, so an opcode
   // carrying X/Z ends up flagged invalid.
   always_comb begin
      ctrl    = CTRL_NOP;
      invalid = 1'b0;
      case (op11)
         OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            ctrl.regwrite = 1'b1;
            ctrl.aluop    = 2'b10;
         end
         OP_LDUR: begin
            ctrl.alusrc   = 2'b01;
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memread  = 1'b1;
         end
         OP_STUR: begin
            ctrl.reg2loc  = 1'b1;
            ctrl.alusrc   = 2'b01;
            ctrl.memwrite = 1'b1;
         end
         OP_ERET: begin
            ctrl.eret = 1'b1;
         end
         default: begin
            if (op11[10:3] == OP_CBZ_PFX) begin
               ctrl.reg2loc = 1'b1;
               ctrl.branch  = 1'b1;
               ctrl.aluop   = 2'b01;
            end
`ifdef EXCDEC_UNCOND_BRANCH_EN
            else if (op11[10:5] == OP_B_PFX) begin
               ctrl.uncondbranch = 1'b1;
            end
`endif
            else begin
               invalid = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/excdec_pipe.sv
// excdec_pipe
// One-stage registered opcode decoder with valid/ready handshake, flush and
// a sticky invalid-opcode exception. An accepted invalid opcode still
// produces a (zeroed) control word, raises Exc and stalls input until the
// handler acknowledges with ExcAck.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready/Op           upstream handshake and opcode
//   flush                          drop the held word and any concurrent input
//   out_valid/out_ready            downstream handshake
//   Reg2Loc..ERet, ALUSrc, ALUOp   registered control word
//   Exc, ExcCause, ExcAck          exception status and acknowledge
// Configuration:
//   EXCDEC_UNCOND_BRANCH_EN  enables decode of B; without it Uncondbranch
//                            is never set by the decoder and stays 0.
module excdec_pipe
   import excdec_pkg::*;
#(
   parameter int OP_W    = 11,
   parameter int CAUSE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    Op,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               Reg2Loc,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               Branch,
   output logic               Uncondbranch,
   output logic               ERet,
   output logic [1:0]         ALUSrc,
   output logic [1:0]         ALUOp,
   output logic               Exc,
   output logic [CAUSE_W-1:0] ExcCause,
   input  logic               ExcAck
);

   state_t             state;
   state_t             state_d;
   logic               exc_d;
   logic [CAUSE_W-1:0] cause_d;
   ctrl_t              dec_ctrl;
   logic               dec_invalid;
   ctrl_t              ctrl_q;
   logic               accept;

   opdec_comb #(.OP_W(OP_W)) u_opdec (
      .Op      (Op),
      .ctrl    (dec_ctrl),
      .invalid (dec_invalid)
   );

   // Ready is held low while reset is asserted so every output reads 0
   // during reset; the register can take a new word whenever it is empty
   // or being drained this cycle.
   assign in_ready = reset && (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready && !flush;

   // Exception FSM: an accepted invalid opcode parks the block in EXC_WAIT
   // until the handler acknowledges. Flush has no effect here because it
   // already suppresses the accept.
   always_comb begin
      state_d = state;
      exc_d   = Exc;
      cause_d = ExcCause;
      case (state)
         RUN: begin
            if (accept && dec_invalid) begin
               state_d = EXC_WAIT;
               exc_d   = 1'b1;
               cause_d = CAUSE_W'(EXC_INVOP);
            end
         end
         EXC_WAIT: begin
            if (ExcAck) begin
               state_d = RUN;
               exc_d   = 1'b0;
               cause_d = CAUSE_W'(EXC_NONE);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // State and exception status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         Exc      <= 1'b0;
         ExcCause <= CAUSE_W'(EXC_NONE);
      end else begin
         state    <= state_d;
         Exc      <= exc_d;
         ExcCause <= cause_d;
      end
   end

   // Output register. Flush wins over everything and only invalidates; the
   // stale control bits are left in place since out_valid qualifies them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         ctrl_q    <= CTRL_NOP;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         ctrl_q    <= dec_ctrl;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign Reg2Loc      = ctrl_q.reg2loc;
   assign ALUSrc       = ctrl_q.alusrc;
   assign MemtoReg     = ctrl_q.memtoreg;
   assign RegWrite     = ctrl_q.regwrite;
   assign MemRead      = ctrl_q.memread;
   assign MemWrite     = ctrl_q.memwrite;
   assign Branch       = ctrl_q.branch;
   assign Uncondbranch = ctrl_q.uncondbranch;
   assign ALUOp        = ctrl_q.aluop;
   assign ERet         = ctrl_q.eret;

endmodule

// File: tb/tb_excdec_pipe.sv
// tb_excdec_pipe
// Self-checking bench for excdec_pipe: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the decode rules.
// Honours EXCDEC_UNCOND_BRANCH_EN the same way as the design.
module tb_excdec_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] Op = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite;
   logic        Branch, Uncondbranch, ERet;
   logic [1:0]  ALUSrc, ALUOp;
   logic        Exc;
   logic [3:0]  ExcCause;
   logic        ExcAck = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic        m_valid;
   logic [12:0] m_word;
   logic        m_wait;
   logic        m_exc;
   logic [3:0]  m_cause;
   logic        exp_ready;
   logic        obs_ready;

   logic [12:0] dut_word;

   // Expected control words, packed as
   // {Reg2Loc, ALUSrc[1:0], MemtoReg, RegWrite, MemRead, MemWrite, Branch, Uncondbranch, ALUOp[1:0], ERet}
   localparam logic [12:0] W_R    = 13'b0_00_0_1_0_0_0_0_10_0;
   localparam logic [12:0] W_LDUR = 13'b0_01_1_1_1_0_0_0_00_0;
   localparam logic [12:0] W_STUR = 13'b1_01_0_0_0_1_0_0_00_0;
   localparam logic [12:0] W_CBZ  = 13'b1_00_0_0_0_0_1_0_01_0;
   localparam logic [12:0] W_ERET = 13'b0_00_0_0_0_0_0_0_00_1;
   localparam logic [12:0] W_B    = 13'b0_00_0_0_0_0_0_1_00_0;

   localparam logic [10:0] C_ADD  = 11'b10001011000;
   localparam logic [10:0] C_SUB  = 11'b11001011000;
   localparam logic [10:0] C_AND  = 11'b10001010000;
   localparam logic [10:0] C_ORR  = 11'b10101010000;
   localparam logic [10:0] C_LDUR = 11'b11111000010;
   localparam logic [10:0] C_STUR = 11'b11111000000;
   localparam logic [10:0] C_ERET = 11'b11010110100;

   assign dut_word = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                      Branch, Uncondbranch, ALUOp, ERet};

   excdec_pipe #(.OP_W(11), .CAUSE_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .Op           (Op),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .Reg2Loc      (Reg2Loc),
      .MemtoReg     (MemtoReg),
      .RegWrite     (RegWrite),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .Branch       (Branch),
      .Uncondbranch (Uncondbranch),
      .ERet         (ERet),
      .ALUSrc       (ALUSrc),
      .ALUOp        (ALUOp),
      .Exc          (Exc),
      .ExcCause     (ExcCause),
      .ExcAck       (ExcAck)
   );

   always #5 clk = ~clk;

   // Returns {invalid, control word} straight from the opcode table.
   function automatic logic [13:0] ref_decode(input logic [10:0] op);
      if (op == C_ADD || op == C_SUB || op == C_AND || op == C_ORR) return {1'b0, W_R};
      if (op == C_LDUR) return {1'b0, W_LDUR};
      if (op == C_STUR) return {1'b0, W_STUR};
      if (op == C_ERET) return {1'b0, W_ERET};
      if (op[10:3] == 8'b10110100) return {1'b0, W_CBZ};
`ifdef EXCDEC_UNCOND_BRANCH_EN
      if (op[10:5] == 6'b000101) return {1'b0, W_B};
`endif
      return {1'b1, 13'b0};
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_word  = '0;
      m_wait  = 1'b0;
      m_exc   = 1'b0;
      m_cause = 4'd0;
   endtask

   // Drives one cycle of inputs, captures in_ready before the edge, then
   // advances the model across the edge. Leaves time at posedge + 1.
   task automatic applyStimulus(input logic iv, input logic [10:0] op,
                                input logic ordy, input logic fl, input logic ack);
      logic        acc;
      logic [13:0] dec;
      @(negedge clk);
      in_valid  = iv;
      Op        = op;
      out_ready = ordy;
      flush     = fl;
      ExcAck    = ack;
      #1;
      exp_ready = !m_wait && (!m_valid || ordy);
      obs_ready = in_ready;
      @(posedge clk);
      acc = iv && exp_ready && !fl;
      dec = ref_decode(op);
      if (fl) m_valid = 1'b0;
      else if (acc) begin
         m_valid = 1'b1;
         m_word  = dec[12:0];
      end else if (ordy) m_valid = 1'b0;
      if (m_wait) begin
         if (ack) begin
            m_wait  = 1'b0;
            m_exc   = 1'b0;
            m_cause = 4'd0;
         end
      end else if (acc && dec[13]) begin
         m_wait  = 1'b1;
         m_exc   = 1'b1;
         m_cause = 4'd2;
      end
      #1;
   endtask

   // Reset state checks while reset is held, then ready after release.
   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
      end
      vectors++;
      if (dut_word !== 13'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl got %b want 0", dut_word);
      end
      vectors++;
      if (Exc !== 1'b0 || ExcCause !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_exc got %b/%b want 0/0000", Exc, ExcCause);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_ldur();
      applyStimulus(1'b1, C_LDUR, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || dut_word !== W_LDUR) begin
         miscompares++;
         $display("[TB] FAIL ldur got v=%b w=%b want v=1 w=%b", out_valid, dut_word, W_LDUR);
      end
      applyStimulus(1'b0, C_LDUR, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ldur_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(1'b1, C_ADD, 1'b0, 1'b0, 1'b0);
      repeat (2) begin
         applyStimulus(1'b1, C_SUB, 1'b0, 1'b0, 1'b0);
         vectors++;
         if (obs_ready !== 1'b0 || out_valid !== 1'b1 || dut_word !== W_R) begin
            miscompares++;
            $display("[TB] FAIL stall_hold got rdy=%b v=%b w=%b want rdy=0 v=1 w=%b",
                     obs_ready, out_valid, dut_word, W_R);
         end
      end
      applyStimulus(1'b1, C_SUB, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs_ready !== 1'b1 || out_valid !== 1'b1 || dut_word !== W_R) begin
         miscompares++;
         $display("[TB] FAIL stall_release got rdy=%b v=%b w=%b want rdy=1 v=1 w=%b",
                  obs_ready, out_valid, dut_word, W_R);
      end
      applyStimulus(1'b1, C_CBZ_OP(), 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs_ready !== 1'b1 || dut_word !== W_CBZ) begin
         miscompares++;
         $display("[TB] FAIL back_to_back got rdy=%b w=%b want rdy=1 w=%b", obs_ready, dut_word, W_CBZ);
      end
      applyStimulus(1'b0, C_ADD, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL no_duplicate got %b want 0", out_valid);
      end
   endtask

   function automatic logic [10:0] C_CBZ_OP();
      return 11'b10110100101;
   endfunction

   task automatic test_exception();
      applyStimulus(1'b1, 11'b11111111111, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (Exc !== 1'b1 || ExcCause !== 4'b0010 || out_valid !== 1'b1 || dut_word !== 13'b0) begin
         miscompares++;
         $display("[TB] FAIL exc_raise got exc=%b cause=%b v=%b w=%b want 1/0010/1/0",
                  Exc, ExcCause, out_valid, dut_word);
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, C_ADD, 1'b1, 1'b0, 1'b0);
         vectors++;
         if (obs_ready !== 1'b0 || Exc !== 1'b1 || ExcCause !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL exc_hold cycle %0d got rdy=%b exc=%b cause=%b want 0/1/0010",
                     i, obs_ready, Exc, ExcCause);
         end
      end
      applyStimulus(1'b0, C_ADD, 1'b1, 1'b0, 1'b1);
      vectors++;
      if (Exc !== 1'b0 || ExcCause !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL exc_ack got exc=%b cause=%b want 0/0000", Exc, ExcCause);
      end
      applyStimulus(1'b0, C_ADD, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL exc_resume_ready got %b want 1", obs_ready);
      end
   endtask

   task automatic test_flush();
      applyStimulus(1'b1, C_STUR, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_drop got %b want 0", out_valid);
      end
      applyStimulus(1'b1, C_ORR, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, C_STUR, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_held got %b want 0", out_valid);
      end
      applyStimulus(1'b0, C_STUR, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b0 || Exc !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL flush_no_stur got v=%b exc=%b want 0/0", out_valid, Exc);
      end
   endtask

   task automatic test_branch();
      applyStimulus(1'b1, 11'b00010100000, 1'b1, 1'b0, 1'b0);
`ifdef EXCDEC_UNCOND_BRANCH_EN
      vectors++;
      if (out_valid !== 1'b1 || dut_word !== W_B || Exc !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL branch_b got v=%b w=%b exc=%b want 1/%b/0", out_valid, dut_word, Exc, W_B);
      end
`else
      vectors++;
      if (Exc !== 1'b1 || ExcCause !== 4'b0010 || Uncondbranch !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL branch_b_invalid got exc=%b cause=%b ub=%b want 1/0010/0",
                  Exc, ExcCause, Uncondbranch);
      end
`endif
      applyStimulus(1'b0, C_ADD, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [10:0] op;
      logic        iv, ordy, fl, ack;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0: op = C_ADD;
            1: op = C_SUB;
            2: op = C_AND;
            3: op = C_ORR;
            4: op = C_LDUR;
            5: op = C_STUR;
            6: op = C_ERET;
            7: op = {8'b10110100, 3'($urandom)};
            8: op = {6'b000101, 5'($urandom)};
            default: op = 11'($urandom);
         endcase
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 9) < 7);
         fl   = ($urandom_range(0, 9) == 0);
         ack  = ($urandom_range(0, 3) == 0);
         applyStimulus(iv, op, ordy, fl, ack);
         vectors++;
         if (obs_ready !== exp_ready) begin
            miscompares++;
            $display("[TB] FAIL rand_in_ready step %0d got %b want %b", n, obs_ready, exp_ready);
         end
         vectors++;
         if (out_valid !== m_valid || Exc !== m_exc || ExcCause !== m_cause) begin
            miscompares++;
            $display("[TB] FAIL rand_status step %0d got v=%b exc=%b cause=%b want %b/%b/%b",
                     n, out_valid, Exc, ExcCause, m_valid, m_exc, m_cause);
         end
         if (m_valid) begin
            vectors++;
            if (dut_word !== m_word) begin
               miscompares++;
               $display("[TB] FAIL rand_word step %0d op=%b got %b want %b", n, op, dut_word, m_word);
            end
         end
      end
      applyStimulus(1'b0, C_ADD, 1'b1, 1'b1, 1'b1);
   endtask

   // Reset asserted mid-cycle must clear everything before the next edge.
   task automatic test_async_reset();
      applyStimulus(1'b1, 11'b00000000000, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || Exc !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL async_setup got v=%b exc=%b want 1/1", out_valid, Exc);
      end
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || Exc !== 1'b0 || ExcCause !== 4'd0 || dut_word !== 13'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL async_reset got v=%b exc=%b cause=%b w=%b rdy=%b want all 0",
                  out_valid, Exc, ExcCause, dut_word, in_ready);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL async_release_ready got %b want 1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_ldur();
      test_back_to_back();
      test_exception();
      test_flush();
      test_branch();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
